hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core (IF, ID, EXE, MEM, WB).
- Consumes decode-stage register addresses and read enables from ID, plus destination and load information from ID_EXE.
- Consumes the MEM-stage data-memory handshake and the EXE-stage branch/jump redirect.
- Drives per-stage stall and flush (bubble-insert) controls to the IF_ID, ID_EXE, EXE_MEM and MEM_WB pipeline registers.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3; 2 for cores without MEM->EXE forwarding)
MEM_TIMEOUT, 255, MEM_WAIT cycles without ack before timeout is flagged (1..2^TO_W-1)
TO_W, 8, width of the timeout counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
id_valid_i  in  1  ID stage holds a valid instruction
id_rs1_addr_i  in  `GPR_ADDR_SPACE  rs1 address from ID
id_rs2_addr_i  in  `GPR_ADDR_SPACE  rs2 address from ID
id_rs1_re_i  in  1  rs1 is read
id_rs2_re_i  in  1  rs2 is read
exe_rd_addr_i  in  `GPR_ADDR_SPACE  rd address in ID_EXE
exe_rd_we_i  in  1  EXE instruction writes rd
exe_mem_re_i  in  1  EXE instruction is a load
exe_redirect_i  in  1  taken branch / JAL / JALR resolved in EXE
mem_req_i  in  1  MEM stage has an outstanding load/store request
mem_ack_i  in  1  data memory completes the request this cycle
stall_if_o  out  1  hold PC and IF_ID
stall_id_o  out  1  hold ID_EXE inputs (ID instruction stays)
stall_exe_o  out  1  hold EXE_MEM
stall_mem_o  out  1  hold MEM stage
flush_ifid_o  out  1  load NOP into IF_ID
flush_idexe_o  out  1  load NOP into ID_EXE
flush_memwb_o  out  1  load NOP into MEM_WB
mem_timeout_o  out  1  sticky timeout flag
stall_cycles_o  out  32  performance counter (see optional feature)
flush_count_o  out  32  performance counter (see optional feature)

Behaviour:
- Reset state: all outputs 0 on rst_i, state RUN, counters 0. Reset asserted mid-stall aborts the stall immediately and asynchronously.
- State machine: RUN, LU_STALL, MEM_WAIT. Priority order is MEM_WAIT > redirect > load-use.
- Load-use hit, combinational:
  - Condition: id_valid_i & exe_mem_re_i & exe_rd_we_i & exe_rd_addr_i!=0, and either (id_rs1_re_i & rs1==rd) or (id_rs2_re_i & rs2==rd).
  - Hit in RUN: stall_if_o=stall_id_o=1 and flush_idexe_o=1 in the same cycle.
  - If LOAD_USE_BUBBLES>1, go to LU_STALL with bub_cnt=LOAD_USE_BUBBLES-1. Otherwise stay in RUN.
- LU_STALL:
  - Each cycle: stall_if_o=stall_id_o=flush_idexe_o=1 and bub_cnt decrements.
  - At bub_cnt==1, next state is RUN. Total bubbles equal LOAD_USE_BUBBLES exactly.
- Memory wait:
  - Condition: mem_req_i & ~mem_ack_i (any state).
  - Response: stall_if/id/exe/mem_o=1 and flush_memwb_o=1, all combinational from the first cycle. Enter MEM_WAIT with to_cnt=1.
  - A bub_cnt in progress is frozen, not lost.
  - In MEM_WAIT, to_cnt saturates at MEM_TIMEOUT. Reaching MEM_TIMEOUT sets mem_timeout_o, which stays set until reset; the stall continues regardless.
  - The cycle mem_ack_i=1: no stall. Next state is LU_STALL if bub_cnt>0, else RUN.
  - Same-cycle mem_req_i & mem_ack_i: zero-wait, no stall.
- Redirect:
  - exe_redirect_i while EXE is not stalled: flush_ifid_o=flush_idexe_o=1 for one cycle, with no IF/ID stall.
  - Redirect overrides a load-use hit and clears bub_cnt (the consumer is killed); next state is RUN.
  - Redirect during MEM_WAIT is ignored; EXE holds it, and it is acted on in the ack cycle.
- Registered state and counters only; all stall and flush outputs are combinational from state + inputs, with zero-cycle latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles_o increments each cycle any stall_*_o=1.
  - flush_count_o increments each cycle flush_ifid_o|flush_idexe_o=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports are still present and tied to 0; no counter flops are built.

Decomposition:
- Shared defines header:
  - state encodings HZ_RUN/HZ_LU_STALL/HZ_MEM_WAIT (2 bits);
  - existing `GPR_ADDR_SPACE;
  - new `PERF_CNT_WIDTH=32.
- One sub-module, hazard_detect: purely combinational load-use comparator producing lu_hit. It is reused later by a forwarding unit.

Test Plan:
- Load-use: EXE=lw x5 (rd_we, mem_re), ID reads rs1=x5, LOAD_USE_BUBBLES=1 -> one cycle of stall_if/id + flush_idexe; next cycle all 0.
- x0 and unread operands:
  - EXE lw x0, ID rs1=x0 -> no stall.
  - EXE lw x7, ID rs2=x7 with rs2_re=0 -> no stall.
- Multi-bubble: LOAD_USE_BUBBLES=2, hit -> exactly 2 cycles of stall + flush_idexe, then RUN.
- Memory wait: mem_req=1, ack at cycle 4 -> stalls/flush_memwb high cycles 1-3, low cycle 4. Separately, MEM_TIMEOUT=5 with no ack for 10 cycles -> mem_timeout_o rises at cycle 5 and stays until rst_i.
- Priority:
  - redirect + load-use hit same cycle -> flush_ifid+flush_idexe, no stall_if.
  - redirect during MEM_WAIT -> flushes only in the ack cycle.
- Async reset mid-LU_STALL (bubbles=3, reset on bubble 2) -> all outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller.
//               Provides the GPR address range, the performance counter
//               width and the controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

`ifndef PERF_CNT_WIDTH
`define PERF_CNT_WIDTH 32
`endif

`default_nettype none

package hazard_ctrl_pkg;

    // Controller states: normal flow, multi-cycle load-use bubble, memory wait
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    // Bubble counter width covers up to three load-use bubbles
    localparam int unsigned c_BUB_W = 2;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. Flags when the valid ID
//               instruction reads a GPR that the load currently in EXE will
//               write. Register x0 never creates a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic                    i_id_valid,
    input  logic [`GPR_ADDR_SPACE]  i_rs1_addr,
    input  logic [`GPR_ADDR_SPACE]  i_rs2_addr,
    input  logic                    i_rs1_re,
    input  logic                    i_rs2_re,
    input  logic [`GPR_ADDR_SPACE]  i_rd_addr,
    input  logic                    i_rd_we,
    input  logic                    i_mem_re,
    output logic                    o_lu_hit
);

    logic w_rd_live;
    logic w_rs1_dep;
    logic w_rs2_dep;

    // A load whose destination is a real register and an operand that is read
    assign w_rd_live = i_id_valid & i_mem_re & i_rd_we & (i_rd_addr != '0);
    assign w_rs1_dep = i_rs1_re & (i_rs1_addr == i_rd_addr);
    assign w_rs2_dep = i_rs2_re & (i_rs2_addr == i_rd_addr);
    assign o_lu_hit  = w_rd_live & (w_rs1_dep | w_rs2_dep);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall / flush controller for the 5-stage core. Handles
//               load-use bubbles, data-memory wait states (with a sticky
//               timeout flag) and EXE-stage redirects. Priority is
//               memory wait > redirect > load-use.
//               Optional macro HAZARD_PERF_CNT_EN builds the stall-cycle and
//               flush-count performance counters; otherwise they read 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_USE_BUBBLES = 1,    // 1..3
    parameter int unsigned MEM_TIMEOUT      = 255,  // 1..2^TO_W-1
    parameter int unsigned TO_W             = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        id_valid_i,
    input  logic [`GPR_ADDR_SPACE]      id_rs1_addr_i,
    input  logic [`GPR_ADDR_SPACE]      id_rs2_addr_i,
    input  logic                        id_rs1_re_i,
    input  logic                        id_rs2_re_i,
    input  logic [`GPR_ADDR_SPACE]      exe_rd_addr_i,
    input  logic                        exe_rd_we_i,
    input  logic                        exe_mem_re_i,
    input  logic                        exe_redirect_i,
    input  logic                        mem_req_i,
    input  logic                        mem_ack_i,
    output logic                        stall_if_o,
    output logic                        stall_id_o,
    output logic                        stall_exe_o,
    output logic                        stall_mem_o,
    output logic                        flush_ifid_o,
    output logic                        flush_idexe_o,
    output logic                        flush_memwb_o,
    output logic                        mem_timeout_o,
    output logic [`PERF_CNT_WIDTH-1:0]  stall_cycles_o,
    output logic [`PERF_CNT_WIDTH-1:0]  flush_count_o
);

    localparam logic [c_BUB_W-1:0] c_bub_init = c_BUB_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [c_BUB_W-1:0] c_bub_one  = c_BUB_W'(1);
    localparam logic [TO_W-1:0]    c_to_max   = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0]    c_to_thr   = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0]    c_to_one   = TO_W'(1);

    hz_state_t          r_state;
    hz_state_t          w_next_state;
    logic [c_BUB_W-1:0] r_bub_cnt;
    logic [c_BUB_W-1:0] w_bub_cnt_next;
    logic [TO_W-1:0]    r_to_cnt;
    logic [TO_W-1:0]    w_to_cnt_next;
    logic               r_timeout;
    logic               w_to_hit;
    logic               w_lu_hit;
    logic               w_mem_wait;
    logic               w_stall_front;
    logic               w_stall_back;
    logic               w_flush_ifid;
    logic               w_flush_idexe;
    logic               w_flush_memwb;

    hazard_detect u_detect (
        .i_id_valid (id_valid_i),
        .i_rs1_addr (id_rs1_addr_i),
        .i_rs2_addr (id_rs2_addr_i),
        .i_rs1_re   (id_rs1_re_i),
        .i_rs2_re   (id_rs2_re_i),
        .i_rd_addr  (exe_rd_addr_i),
        .i_rd_we    (exe_rd_we_i),
        .i_mem_re   (exe_mem_re_i),
        .o_lu_hit   (w_lu_hit)
    );

    assign w_mem_wait = mem_req_i & ~mem_ack_i;

    // Next-state and stall/flush decode; memory wait dominates, then redirect, then load-use
    always_comb begin
        w_next_state   = r_state;
        w_bub_cnt_next = r_bub_cnt;
        w_to_cnt_next  = r_to_cnt;
        w_to_hit       = 1'b0;
        w_stall_front  = 1'b0;
        w_stall_back   = 1'b0;
        w_flush_ifid   = 1'b0;
        w_flush_idexe  = 1'b0;
        w_flush_memwb  = 1'b0;

        if (w_mem_wait) begin
            // Freeze the whole pipe; pending bubbles are preserved untouched
            w_stall_front = 1'b1;
            w_stall_back  = 1'b1;
            w_flush_memwb = 1'b1;
            w_next_state  = HZ_MEM_WAIT;
            if (r_state == HZ_MEM_WAIT) begin
                // r_to_cnt holds the number of wait cycles already elapsed
                w_to_hit = (r_to_cnt >= c_to_thr);
                if (r_to_cnt < c_to_max) begin
                    w_to_cnt_next = r_to_cnt + c_to_one;
                end
            end else begin
                w_to_hit      = (MEM_TIMEOUT == 1);
                w_to_cnt_next = c_to_one;
            end
        end else begin
            w_to_cnt_next = '0;
            if (exe_redirect_i) begin
                // The dependent consumer is on the wrong path, so drop its bubbles
                w_flush_ifid   = 1'b1;
                w_flush_idexe  = 1'b1;
                w_bub_cnt_next = '0;
                w_next_state   = HZ_RUN;
            end else if ((r_state == HZ_MEM_WAIT) && (r_bub_cnt != '0)) begin
                // Ack cycle: resume the interrupted bubble sequence next cycle
                w_next_state = HZ_LU_STALL;
            end else if (r_state == HZ_LU_STALL) begin
                w_stall_front  = 1'b1;
                w_flush_idexe  = 1'b1;
                w_bub_cnt_next = r_bub_cnt - c_bub_one;
                w_next_state   = (r_bub_cnt == c_bub_one) ? HZ_RUN : HZ_LU_STALL;
            end else if (w_lu_hit) begin
                w_stall_front  = 1'b1;
                w_flush_idexe  = 1'b1;
                w_bub_cnt_next = c_bub_init;
                w_next_state   = (LOAD_USE_BUBBLES > 1) ? HZ_LU_STALL : HZ_RUN;
            end else begin
                w_next_state = HZ_RUN;
            end
        end
    end

    // State, bubble counter, timeout counter and sticky timeout flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= HZ_RUN;
            r_bub_cnt <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_bub_cnt <= w_bub_cnt_next;
            r_to_cnt  <= w_to_cnt_next;
            r_timeout <= r_timeout | w_to_hit;
        end
    end

    // Reset forces every control low immediately, even with live inputs
    assign stall_if_o    = ~rst_i & w_stall_front;
    assign stall_id_o    = ~rst_i & w_stall_front;
    assign stall_exe_o   = ~rst_i & w_stall_back;
    assign stall_mem_o   = ~rst_i & w_stall_back;
    assign flush_ifid_o  = ~rst_i & w_flush_ifid;
    assign flush_idexe_o = ~rst_i & w_flush_idexe;
    assign flush_memwb_o = ~rst_i & w_flush_memwb;
    assign mem_timeout_o = ~rst_i & (r_timeout | w_to_hit);

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [`PERF_CNT_WIDTH-1:0] c_cnt_one = `PERF_CNT_WIDTH'(1);

    logic [`PERF_CNT_WIDTH-1:0] r_stall_cycles;
    logic [`PERF_CNT_WIDTH-1:0] r_flush_count;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_front | w_stall_back) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
            if (w_flush_ifid | w_flush_idexe) begin
                r_flush_count <= r_flush_count + c_cnt_one;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Three instances with
//               different bubble counts / timeouts share one stimulus stream
//               and are compared against a cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

    localparam int N = 3;

    function automatic int bub_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int to_of(input int i);
        case (i)
            0:       return 5;
            1:       return 255;
            default: return 3;
        endcase
    endfunction

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs1_addr_i = '0;
    logic [4:0] id_rs2_addr_i = '0;
    logic       id_rs1_re_i = 1'b0;
    logic       id_rs2_re_i = 1'b0;
    logic [4:0] exe_rd_addr_i = '0;
    logic       exe_rd_we_i = 1'b0;
    logic       exe_mem_re_i = 1'b0;
    logic       exe_redirect_i = 1'b0;
    logic       mem_req_i = 1'b0;
    logic       mem_ack_i = 1'b0;

    logic [N-1:0] stall_if, stall_id, stall_exe, stall_mem;
    logic [N-1:0] flush_ifid, flush_idexe, flush_memwb, tmo;
    logic [31:0]  sc [N];
    logic [31:0]  fc [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_ctrl #(
            .LOAD_USE_BUBBLES (bub_of(g)),
            .MEM_TIMEOUT      (to_of(g)),
            .TO_W             (8)
        ) u_dut (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .id_valid_i     (id_valid_i),
            .id_rs1_addr_i  (id_rs1_addr_i),
            .id_rs2_addr_i  (id_rs2_addr_i),
            .id_rs1_re_i    (id_rs1_re_i),
            .id_rs2_re_i    (id_rs2_re_i),
            .exe_rd_addr_i  (exe_rd_addr_i),
            .exe_rd_we_i    (exe_rd_we_i),
            .exe_mem_re_i   (exe_mem_re_i),
            .exe_redirect_i (exe_redirect_i),
            .mem_req_i      (mem_req_i),
            .mem_ack_i      (mem_ack_i),
            .stall_if_o     (stall_if[g]),
            .stall_id_o     (stall_id[g]),
            .stall_exe_o    (stall_exe[g]),
            .stall_mem_o    (stall_mem[g]),
            .flush_ifid_o   (flush_ifid[g]),
            .flush_idexe_o  (flush_idexe[g]),
            .flush_memwb_o  (flush_memwb[g]),
            .mem_timeout_o  (tmo[g]),
            .stall_cycles_o (sc[g]),
            .flush_count_o  (fc[g])
        );
    end

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: pending bubbles, wait tracking, sticky flag, counters
    int          m_bub   [N];
    bit          m_wait  [N];
    int          m_wcnt  [N];
    bit          m_tflag [N];
    int unsigned m_sc    [N];
    int unsigned m_fc    [N];

    function automatic logic [7:0] obs(input int i);
        return {stall_if[i], stall_id[i], stall_exe[i], stall_mem[i],
                flush_ifid[i], flush_idexe[i], flush_memwb[i], tmo[i]};
    endfunction

    // Expected outputs {sif,sid,sexe,smem,fifid,fidexe,fmw,tmo} and next model state
    function automatic void model_eval(input int i, output logic [7:0] e, output int nb,
                                       output bit nw, output int nwc, output bit ntf);
        bit hit;
        bit wt;
        int w;
        hit = id_valid_i && exe_mem_re_i && exe_rd_we_i && (exe_rd_addr_i != 0) &&
              ((id_rs1_re_i && id_rs1_addr_i == exe_rd_addr_i) ||
               (id_rs2_re_i && id_rs2_addr_i == exe_rd_addr_i));
        wt  = mem_req_i && !mem_ack_i;
        e   = '0;
        nb  = m_bub[i];
        nw  = 1'b0;
        nwc = 0;
        ntf = m_tflag[i];
        if (rst_i) begin
            nb  = 0;
            ntf = 1'b0;
            return;
        end
        if (wt) begin
            w   = m_wait[i] ? m_wcnt[i] + 1 : 1;
            e   = 8'b1111_0010;
            ntf = m_tflag[i] || (w >= to_of(i));
            nw  = 1'b1;
            nwc = (w > to_of(i)) ? to_of(i) : w;
        end else if (exe_redirect_i) begin
            e  = 8'b0000_1100;
            nb = 0;
        end else if (m_wait[i] && m_bub[i] > 0) begin
            e = '0;
        end else if (m_bub[i] > 0) begin
            e  = 8'b1100_0100;
            nb = m_bub[i] - 1;
        end else if (hit) begin
            e  = 8'b1100_0100;
            nb = bub_of(i) - 1;
        end
        e[0] = ntf;
    endfunction

    // Compare all instances against the model, then advance one clock
    task automatic tick(input string tag);
        logic [7:0]  e   [N];
        int          nb  [N];
        bit          nw  [N];
        int          nwc [N];
        bit          ntf [N];
        logic [31:0] esc, efc;
        #1;
        for (int i = 0; i < N; i++) begin
            model_eval(i, e[i], nb[i], nw[i], nwc[i], ntf[i]);
            n_checks++;
            if (obs(i) !== e[i])
                $display("FAIL %s dut%0d: outputs %b, expected %b", tag, i, obs(i), e[i]);
            else
                n_pass++;
`ifdef HAZARD_PERF_CNT_EN
            esc = rst_i ? 32'd0 : 32'(m_sc[i]);
            efc = rst_i ? 32'd0 : 32'(m_fc[i]);
`else
            esc = 32'd0;
            efc = 32'd0;
`endif
            n_checks++;
            if (sc[i] !== esc || fc[i] !== efc)
                $display("FAIL %s_perf dut%0d: stall_cycles %0d flush_count %0d, expected %0d %0d",
                         tag, i, sc[i], fc[i], esc, efc);
            else
                n_pass++;
        end
        @(posedge clk_i);
        for (int i = 0; i < N; i++) begin
            m_bub[i]   = nb[i];
            m_wait[i]  = nw[i];
            m_wcnt[i]  = nwc[i];
            m_tflag[i] = ntf[i];
            if (rst_i) begin
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                if (e[i][7:4] != 0) m_sc[i] = m_sc[i] + 1;
                if (e[i][3] || e[i][2]) m_fc[i] = m_fc[i] + 1;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input int r1, input bit e1, input int r2, input bit e2,
                         input int rd, input bit we, input bit mre, input bit redir,
                         input bit req, input bit ack);
        id_valid_i     = v;
        id_rs1_addr_i  = 5'(r1);
        id_rs1_re_i    = e1;
        id_rs2_addr_i  = 5'(r2);
        id_rs2_re_i    = e2;
        exe_rd_addr_i  = 5'(rd);
        exe_rd_we_i    = we;
        exe_mem_re_i   = mre;
        exe_redirect_i = redir;
        mem_req_i      = req;
        mem_ack_i      = ack;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hit_x5();
        drive(1, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    endtask

    task automatic settle();
        idle();
        for (int c = 0; c < 4; c++) tick("settle");
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b1;
        tick("reset");
        tick("reset_hold");
        rst_i = 1'b0;
        tick("reset_release");
    endtask

    task automatic test_load_use();
        settle();
        hit_x5();
        tick("lu_hit");
        idle();
        for (int c = 0; c < 4; c++) tick("lu_after");
    endtask

    task automatic test_x0_unread();
        settle();
        drive(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (stall_if !== '0) $display("FAIL x0_dep: stall_if %b, expected 000", stall_if);
        else n_pass++;
        tick("x0_dep");
        drive(1, 0, 0, 7, 0, 7, 1, 1, 0, 0, 0);
        #1;
        n_checks++;
        if (stall_if !== '0) $display("FAIL rs2_unread: stall_if %b, expected 000", stall_if);
        else n_pass++;
        tick("rs2_unread");
        drive(1, 0, 0, 7, 1, 7, 1, 1, 0, 0, 0);
        tick("rs2_read");
        settle();
    endtask

    task automatic test_multi_bubble();
        int cnt [N];
        settle();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        hit_x5();
        for (int c = 0; c < 6; c++) begin
            #1;
            for (int i = 0; i < N; i++) cnt[i] += int'(stall_if[i] & flush_idexe[i]);
            tick("multi_bubble");
            idle();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (cnt[i] !== bub_of(i))
                $display("FAIL bubble_count dut%0d: got %0d bubbles, expected %0d", i, cnt[i], bub_of(i));
            else
                n_pass++;
        end
    endtask

    task automatic test_mem_wait();
        int cnt;
        settle();
        cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 3)      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else if (c == 4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            else             idle();
            #1;
            cnt += int'(stall_mem[1] & flush_memwb[1]);
            if (c == 4) begin
                n_checks++;
                if ({stall_if[1], stall_exe[1], flush_memwb[1]} !== 3'b000)
                    $display("FAIL mem_ack_cycle: stall_if/exe/flush_memwb %b, expected 000",
                             {stall_if[1], stall_exe[1], flush_memwb[1]});
                else
                    n_pass++;
            end
            tick("mem_wait");
        end
        n_checks++;
        if (cnt !== 3) $display("FAIL mem_wait_len: %0d stall cycles, expected 3", cnt);
        else n_pass++;
        // Same-cycle request and acknowledge never stalls
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick("zero_wait");
    endtask

    task automatic test_timeout();
        settle();
        rst_i = 1'b1;
        tick("to_reset");
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int c = 1; c <= 10; c++) begin
            #1;
            n_checks++;
            if ({tmo[2], tmo[0]} !== {1'(c >= 3), 1'(c >= 5)})
                $display("FAIL timeout_rise cycle %0d: tmo[2],tmo[0]=%b, expected %b",
                         c, {tmo[2], tmo[0]}, {1'(c >= 3), 1'(c >= 5)});
            else
                n_pass++;
            tick("timeout");
        end
        idle();
        tick("timeout_sticky");
        tick("timeout_sticky");
        n_checks++;
        if (tmo[0] !== 1'b1) $display("FAIL timeout_hold: tmo %b, expected 1", tmo[0]);
        else n_pass++;
        rst_i = 1'b1;
        tick("timeout_clear");
        rst_i = 1'b0;
        tick("timeout_cleared");
    endtask

    task automatic test_priority();
        settle();
        // Redirect wins over a load-use hit
        drive(1, 5, 1, 0, 0, 5, 1, 1, 1, 0, 0);
        #1;
        n_checks++;
        if ({flush_ifid[2], flush_idexe[2], stall_if[2]} !== 3'b110)
            $display("FAIL redirect_vs_lu: flush_ifid/idexe/stall_if %b, expected 110",
                     {flush_ifid[2], flush_idexe[2], stall_if[2]});
        else
            n_pass++;
        tick("redirect_lu");
        idle();
        tick("redirect_after");
        tick("redirect_after");
        // Redirect held during a memory wait acts only in the ack cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick("redirect_memwait");
        tick("redirect_memwait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tick("redirect_ack");
        idle();
        tick("redirect_ack_after");
        // Memory wait in the middle of a bubble sequence freezes it
        settle();
        hit_x5();
        tick("freeze_hit");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("freeze_wait");
        tick("freeze_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick("freeze_ack");
        idle();
        for (int c = 0; c < 4; c++) tick("freeze_resume");
    endtask

    task automatic test_async_reset();
        settle();
        hit_x5();
        tick("arst_bubble1");
        idle();
        // Assert reset between clock edges while dut2 is on its second bubble
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({stall_if, stall_id, flush_idexe} !== '0)
            $display("FAIL async_reset: stall_if/id/flush_idexe %b, expected 0",
                     {stall_if, stall_id, flush_idexe});
        else
            n_pass++;
        tick("arst_asserted");
        rst_i = 1'b0;
        tick("arst_release");
        n_checks++;
        if (stall_if[2] !== 1'b0) $display("FAIL arst_run: stall_if %b, expected 0", stall_if[2]);
        else n_pass++;
        tick("arst_run");
    endtask

    task automatic test_random();
        bit req;
        settle();
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 9) < 8,
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
                  int'($urandom_range(0, 3)), $urandom_range(0, 9) < 8,
                  $urandom_range(0, 1) == 1,  $urandom_range(0, 9) == 0,
                  req, req && ($urandom_range(0, 1) == 1));
            tick("random");
        end
        idle();
        tick("random_end");
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_bub[i] = 0; m_wait[i] = 0; m_wcnt[i] = 0; m_tflag[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        test_reset();
        test_load_use();
        test_x0_unread();
        test_multi_bubble();
        test_mem_wait();
        test_timeout();
        test_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
